// File: rtl/time_set_ctrl.sv
// time_set_ctrl -- time-of-day keeper with button-driven setting
//
// Keeps a 24-hour BCD clock (HOUR:MIN:SEC). It advances once per ENABLE_Hz
// tick in RUN. The mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
// In the SET states time is frozen and the up button increments the field
// being set. The field being set blinks at half the tick rate through the
// BLANK_* outputs. Leaving SET_MIN zeroes the seconds.
//
// Ports
//   CLK        in   system clock, rising-edge active
//   RST        in   synchronous active-high reset
//   ENABLE_Hz  in   one-cycle 1 Hz tick
//   BAP_MODE   in   one-cycle mode button press
//   BAP_UP     in   one-cycle increment button press
//   HOUR       out  BCD hours   00-23
//   MIN        out  BCD minutes 00-59
//   SEC        out  BCD seconds 00-59
//   MODE       out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   BLANK_H    out  hour digits blanked (blink off phase)
//   BLANK_M    out  minute digits blanked (blink off phase)
module time_set_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE_Hz,
  input  logic       BAP_MODE,
  input  logic       BAP_UP,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [1:0] MODE,
  output logic       BLANK_H,
  output logic       BLANK_M
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  logic [1:0] state_r, state_d;
  logic [7:0] hour_r, hour_d;
  logic [7:0] min_r, min_d;
  logic [7:0] sec_r, sec_d;
  logic       blink_r, blink_d;
  logic       blank_h_r, blank_m_r;
  logic [8:0] sec_inc, min_inc;

  // Modulo-60 BCD increment; bit 8 is the wrap (carry-out) flag.
  function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
    if (v == 8'h59)
      return 9'h100;
    else if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Modulo-24 BCD increment; the day wrap has nowhere to carry.
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sec_inc = bcd_inc60(sec_r);
  assign min_inc = bcd_inc60(min_r);

  always_comb begin
    state_d = state_r;
    hour_d  = hour_r;
    min_d   = min_r;
    sec_d   = sec_r;
    blink_d = blink_r;
    case (state_r)
      ST_RUN: begin
        // A tick coinciding with the mode press still counts.
        // BAP_UP has no effect here.
        blink_d = 1'b0;
        if (ENABLE_Hz) begin
          sec_d = sec_inc[7:0];
          if (sec_inc[8]) begin
            min_d = min_inc[7:0];
            if (min_inc[8])
              hour_d = bcd_inc24(hour_r);
          end
        end
        if (BAP_MODE)
          state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        // Mode press wins over a simultaneous up press.
        if (BAP_MODE) begin
          state_d = ST_SET_MIN;
          blink_d = 1'b0;
        end else if (BAP_UP) begin
          hour_d  = bcd_inc24(hour_r);
          blink_d = 1'b0;
        end else if (ENABLE_Hz) begin
          blink_d = ~blink_r;
        end
      end
      ST_SET_MIN: begin
        if (BAP_MODE) begin
          state_d = ST_RUN;
          sec_d   = 8'h00;
          blink_d = 1'b0;
        end else if (BAP_UP) begin
          min_d   = min_inc[7:0];
          blink_d = 1'b0;
        end else if (ENABLE_Hz) begin
          blink_d = ~blink_r;
        end
      end
      default: begin
        // Illegal encoding: recover to RUN without disturbing the time.
        state_d = ST_RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_RUN;
      hour_r    <= 8'h00;
      min_r     <= 8'h00;
      sec_r     <= 8'h00;
      blink_r   <= 1'b0;
      blank_h_r <= 1'b0;
      blank_m_r <= 1'b0;
    end else begin
      state_r   <= state_d;
      hour_r    <= hour_d;
      min_r     <= min_d;
      sec_r     <= sec_d;
      blink_r   <= blink_d;
      // Blank flags are registered from next-state values so they line up
      // with MODE on the same edge.
      blank_h_r <= blink_d & (state_d == ST_SET_HOUR);
      blank_m_r <= blink_d & (state_d == ST_SET_MIN);
    end
  end

  assign HOUR    = hour_r;
  assign MIN     = min_r;
  assign SEC     = sec_r;
  assign MODE    = state_r;
  assign BLANK_H = blank_h_r;
  assign BLANK_M = blank_m_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl -- self-checking bench for time_set_ctrl
//
// Drives directed scenarios followed by randomized button and tick traffic.
// Every cycle is compared against a reference model. The model keeps the time
// as plain integers (hours, minutes, seconds) and advances RUN time through
// a seconds-of-day count modulo 86400.
module tb_time_set_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ENABLE_Hz = 1'b0;
  logic       BAP_MODE = 1'b0;
  logic       BAP_UP = 1'b0;
  logic [7:0] HOUR, MIN, SEC;
  logic [1:0] MODE;
  logic       BLANK_H, BLANK_M;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_h = 0, m_m = 0, m_s = 0;
  int m_mode = 0;
  bit m_blink = 1'b0;

  time_set_ctrl dut (
    .CLK(CLK), .RST(RST), .ENABLE_Hz(ENABLE_Hz), .BAP_MODE(BAP_MODE),
    .BAP_UP(BAP_UP), .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .MODE(MODE),
    .BLANK_H(BLANK_H), .BLANK_M(BLANK_M)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit bm,
                            input bit bu);
    int tod;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (en) begin
          tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
        end
        if (bm) m_mode = 1;
        m_blink = 0;
      end
      1: begin
        if (bm) begin m_mode = 2; m_blink = 0; end
        else if (bu) begin m_h = (m_h + 1) % 24; m_blink = 0; end
        else if (en) m_blink = ~m_blink;
      end
      default: begin
        if (bm) begin m_mode = 0; m_s = 0; m_blink = 0; end
        else if (bu) begin m_m = (m_m + 1) % 60; m_blink = 0; end
        else if (en) m_blink = ~m_blink;
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("HOUR", 32'(HOUR), 32'(to_bcd(m_h)));
    check_eq("MIN", 32'(MIN), 32'(to_bcd(m_m)));
    check_eq("SEC", 32'(SEC), 32'(to_bcd(m_s)));
    check_eq("MODE", 32'(MODE), 32'(m_mode));
    check_eq("BLANK_H", 32'(BLANK_H), 32'(m_blink && m_mode == 1));
    check_eq("BLANK_M", 32'(BLANK_M), 32'(m_blink && m_mode == 2));
  endtask

  // One clock cycle: apply inputs, step model on the edge, compare after it.
  task automatic cyc(input bit en, input bit bm, input bit bu, input bit rst);
    ENABLE_Hz = en; BAP_MODE = bm; BAP_UP = bu; RST = rst;
    @(posedge CLK);
    model_step(rst, en, bm, bu);
    #1;
    compare_all();
    ENABLE_Hz = 0; BAP_MODE = 0; BAP_UP = 0; RST = 0;
  endtask

  // From RUN: set hour and minute through the SET states, then tick to sec.
  task automatic set_time(input int h, input int m, input int s);
    int n;
    cyc(0, 1, 0, 0);
    n = (h - m_h + 24) % 24;
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    n = (m - m_m + 60) % 60;
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < s; i++) cyc(1, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] hold;
    int toggles;
    logic prev;

    // Reset state
    cyc(0, 0, 0, 1);
    check_eq("rst_hour", 32'(HOUR), 32'h00);
    check_eq("rst_mode", 32'(MODE), 32'h0);

    // First tick after reset
    cyc(1, 0, 0, 0);
    check_eq("first_tick_sec", 32'(SEC), 32'h01);

    // Day rollover in one tick
    cyc(0, 0, 0, 1);
    set_time(23, 59, 59);
    check_eq("pre_roll", {8'h0, HOUR, MIN, SEC}, 32'h00235959);
    cyc(1, 0, 0, 0);
    check_eq("day_roll", {8'h0, HOUR, MIN, SEC}, 32'h00000000);

    // BCD tens carries
    set_time(9, 59, 59);
    cyc(1, 0, 0, 0);
    check_eq("carry_10", {8'h0, HOUR, MIN, SEC}, 32'h00100000);
    set_time(19, 59, 59);
    cyc(1, 0, 0, 0);
    check_eq("carry_20", {8'h0, HOUR, MIN, SEC}, 32'h00200000);

    // Full setting walk from 12:34:56
    set_time(12, 34, 56);
    check_eq("t123456", {8'h0, HOUR, MIN, SEC}, 32'h00123456);
    cyc(0, 1, 0, 0);
    check_eq("to_set_hour", 32'(MODE), 32'h1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
    check_eq("hour_wrap", 32'(HOUR), 32'h00);
    cyc(0, 1, 0, 0);
    check_eq("to_set_min", 32'(MODE), 32'h2);
    for (int i = 0; i < 26; i++) cyc(0, 0, 1, 0);
    check_eq("min_wrap", {16'h0, HOUR, MIN}, 32'h0000);
    cyc(0, 1, 0, 0);
    check_eq("exit_mode", 32'(MODE), 32'h0);
    check_eq("exit_sec", 32'(SEC), 32'h00);

    // Minute wrap without hour carry, frozen time and blink in SET_MIN
    set_time(5, 0, 17);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 1, 0);
    check_eq("min59", 32'(MIN), 32'h59);
    cyc(0, 0, 1, 0);
    check_eq("min_wrap_nocarry", {16'h0, HOUR, MIN}, 32'h0500);
    hold = SEC;
    toggles = 0;
    prev = BLANK_M;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      if (BLANK_M !== prev) toggles++;
      prev = BLANK_M;
    end
    check_eq("frozen_sec", 32'(SEC), 32'(hold));
    check_eq("blank_m_toggles", 32'(toggles), 32'd5);
    cyc(0, 1, 0, 0);

    // Mode and up together in SET_HOUR
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    hold = HOUR;
    cyc(0, 1, 1, 0);
    check_eq("mode_up_mode", 32'(MODE), 32'h2);
    check_eq("mode_up_hour", 32'(HOUR), 32'(hold));
    check_eq("mode_up_blank", 32'(BLANK_M), 32'h0);
    cyc(0, 1, 0, 0);

    // Reset mid-SET with blink on
    set_time(7, 45, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check_eq("blink_on", 32'(BLANK_M), 32'h1);
    cyc(0, 0, 0, 1);
    check_eq("rst_mid_set", {6'h0, MODE, HOUR, MIN, SEC}, 32'h0);
    check_eq("rst_blank", {30'h0, BLANK_H, BLANK_M}, 32'h0);

    // Tick plus mode press together in RUN
    cyc(1, 1, 0, 0);
    check_eq("tick_mode_sec", 32'(SEC), 32'h01);
    check_eq("tick_mode_mode", 32'(MODE), 32'h1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset named RST.
REQ-002 CLK  in  1  system clock; all state updates on its rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 ENABLE_Hz  in  1  one-CLK-wide tick at 1 Hz from the prescaler.
REQ-005 BAP_MODE  in  1  one-CLK-wide debounced press pulse, mode button.
REQ-006 BAP_UP  in  1  one-CLK-wide debounced press pulse, increment button.
REQ-007 HOUR  out  8  BCD hours: [7:4] tens 0-2, [3:0] units 0-9; range 00-23.
REQ-008 MIN  out  8  BCD minutes: [7:4] tens 0-5, [3:0] units 0-9; range 00-59.
REQ-009 SEC  out  8  BCD seconds, same encoding and range as MIN.
REQ-010 MODE  out  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-011 BLANK_H  out  1  1 = hour digits blanked (blink phase off).
REQ-012 BLANK_M  out  1  1 = minute digits blanked.

Function
REQ-013 All outputs SHALL be registered; each response appears on the CLK edge that samples the causing input.
REQ-014 State machine: RUN --BAP_MODE--> SET_HOUR --BAP_MODE--> SET_MIN --BAP_MODE--> RUN; no other transitions except reset.
REQ-015 RUN, ENABLE_Hz=1: SEC +1 BCD; SEC 59->00 with carry into MIN.
REQ-016 RUN, carry into MIN: MIN 59->00 with carry into HOUR.
REQ-017 RUN, carry into HOUR: HOUR 23->00; the rollover 23:59:59 -> 00:00:00 completes in one tick.
REQ-018 BCD increment rule: units 9->0 with tens +1 (09->10, 19->20); no non-BCD code ever appears on HOUR/MIN/SEC.
REQ-019 SET_HOUR/SET_MIN: ENABLE_Hz SHALL NOT advance SEC, MIN or HOUR; time is frozen.
REQ-020 SET_HOUR, BAP_UP=1: HOUR +1 mod 24 (23->00); MIN and SEC unchanged.
REQ-021 SET_MIN, BAP_UP=1: MIN +1 mod 60 (59->00) with no carry into HOUR; SEC unchanged.
REQ-022 RUN, BAP_UP: ignored.
REQ-023 Transition SET_MIN->RUN SHALL load SEC=00 on the same edge; counting resumes at the next ENABLE_Hz.
REQ-024 BAP_MODE and BAP_UP in the same cycle: the mode transition is taken and BAP_UP is dropped.
REQ-025 RUN, BAP_MODE and ENABLE_Hz in the same cycle: the tick is applied (time advances) and the state moves to SET_HOUR.
REQ-026 Internal BLINK bit: toggles on each ENABLE_Hz while in a SET state; forced to 0 in RUN, on every state transition, and on every accepted BAP_UP.
REQ-027 BLANK_H = BLINK & (state==SET_HOUR).
REQ-028 BLANK_M = BLINK & (state==SET_MIN).
REQ-029 Both BLANK outputs SHALL be 0 in RUN.
REQ-030 Unreachable state 11 SHALL return to RUN on the next edge with time values held.

Reset
REQ-031 RST=1 at a CLK edge: HOUR=00, MIN=00, SEC=00, MODE=00 (RUN), BLINK=0, BLANK_H=0, BLANK_M=0.
REQ-032 RST has priority over all other inputs, including mid-SET operation; no pending pulse survives reset.
REQ-033 The first ENABLE_Hz after RST deasserts SHALL produce SEC=01.

Verification
REQ-034 Preset 23:59:59 via SET states plus 59 ticks, then one ENABLE_Hz in RUN -> 00:00:00.
REQ-035 RUN 12:34:56, BAP_MODE -> MODE=01. BAP_UP x12 -> HOUR=00. BAP_MODE -> MODE=10. BAP_UP x26 -> MIN=00, HOUR=00. BAP_MODE -> MODE=00, SEC=00.
REQ-036 SET_MIN, MIN=59, BAP_UP -> MIN=00, HOUR unchanged; ENABLE_Hz x5 in SET_MIN -> SEC unchanged, BLANK_M toggles 5 times.
REQ-037 SET_HOUR, BAP_MODE and BAP_UP in the same cycle -> MODE=10, HOUR unchanged, BLANK_M=0.
REQ-038 SET_MIN at 07:45, BLINK=1, assert RST for 1 cycle -> 00:00:00, MODE=00, BLANK_H=BLANK_M=0.
REQ-039 RUN at 09:59:59, ENABLE_Hz -> 10:00:00; at 19:59:59, ENABLE_Hz -> 20:00:00 (BCD tens carry).
